conv_sequencer: RTL and testbench
=================================

Name: conv_sequencer

Overview:
- Top-level control FSM for the 1-D convolution engine. It sequences memory load, per-output MAC bursts and result handoff.
- Produces `mem_wr_state`, `in_compute`, `incr_comp_cyc` and `compute_cyc` for the memory read-address controller.
- Produces write enables/addresses for the X and F memories, accumulator clear/enable, and the output valid/ready handshake.
- Sits between the stream interface and the MAC datapath; contains no data path itself.

Parameters:
- DATA_N, 8, number of X samples
- LG_DATA_N, 3, width of X address
- FILTER_N, 4, number of filter taps
- LG_FILTER_N, 2, width of F address
- LG_CONV_N, 3, width of output index; CONV_N = DATA_N-FILTER_N+1 (local, 5 by default)
- RD_LAT, 1, memory read latency in cycles (>=1)

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- in_valid  in  1  input sample valid
- in_ready  out  1  controller accepts a sample
- wr_en_x  out  1  write X memory this cycle
- wr_addr_x  out  LG_DATA_N  X write address
- wr_en_f  out  1  write F memory this cycle
- wr_addr_f  out  LG_FILTER_N  F write address
- mem_wr_state  out  1  load phase active
- in_compute  out  1  MAC read cycle active
- incr_comp_cyc  out  1  one-cycle pulse: advance to next output
- compute_cyc  out  LG_CONV_N  index of current output
- acc_clr  out  1  accumulator load (first tap)
- acc_en  out  1  accumulator update
- out_valid  in/out: out  1  result valid
- out_ready  in  1  consumer accepts result
- done  out  1  one-cycle pulse after last result accepted

Behaviour:
- Interface: one clock `clk`; reset `reset_n` is asynchronous and active-low. While reset_n=0, all state and counters return to reset values immediately.
- Reset state is LOAD:
  - `load_cnt`, `mac_cnt`, `compute_cyc` = 0; RD_LAT delay line cleared.
  - `mem_wr_state` = 1 and `in_ready` = 1 (decoded from LOAD).
  - All other outputs = 0.
- States: LOAD, COMPUTE, DRAIN, OUT, REINIT.
- LOAD:
  - `in_ready` = 1. A handshake is `in_valid & in_ready`.
  - Handshakes 0..DATA_N-1: `wr_en_x` = 1, `wr_addr_x` = `load_cnt`.
  - Handshakes DATA_N..DATA_N+FILTER_N-1: `wr_en_f` = 1, `wr_addr_f` = `load_cnt`-DATA_N.
  - Write enables are combinational from the handshake (same cycle); `load_cnt` increments on the handshake edge.
  - On the final handshake: go to COMPUTE, `load_cnt` = 0, `mac_cnt` = 0, `compute_cyc` = 0.
  - `in_valid` gaps simply stall; no timeout.
- COMPUTE:
  - `in_compute` = 1; `mac_cnt` counts 0..FILTER_N-1, exactly FILTER_N cycles.
  - When `mac_cnt` = FILTER_N-1, go to DRAIN.
- Accumulator controls:
  - `acc_en` = `in_compute` delayed RD_LAT cycles.
  - `acc_clr` = (`in_compute` & `mac_cnt`==0) delayed RD_LAT cycles.
  - Both come from a registered shift line.
- DRAIN: lasts RD_LAT cycles. If the last `in_compute` cycle is T, the last `acc_en` is at T+RD_LAT, and OUT is entered at T+RD_LAT+1.
- OUT:
  - `out_valid` = 1, held until `out_ready`; stays stable under backpressure.
  - On handshake with `compute_cyc` < CONV_N-1:
    - `incr_comp_cyc` = 1 in the handshake cycle.
    - `compute_cyc` increments at that edge.
    - Go to REINIT.
  - On handshake with `compute_cyc` = CONV_N-1:
    - `done` = 1 in the following cycle.
    - Go to LOAD; `compute_cyc` = 0.
    - `incr_comp_cyc` is not asserted.
- REINIT: exactly 2 cycles with all strobes low (gives the read controller time to reinitialise addresses), then COMPUTE with `mac_cnt` = 0.
- Outside LOAD: `in_ready` = 0 and `in_valid` is ignored (no writes, no counter change).
- Output `mem_wr_state` = 1 only in LOAD.
- `in_compute`, `incr_comp_cyc` and `wr_en_*` are mutually exclusive.
- Counters never wrap silently; every terminal compare uses ==.
- With the defaults and `out_ready` = 1, one output costs 4 (COMPUTE) + 1 (DRAIN) + 1 (OUT) + 2 (REINIT) = 8 cycles.

Test Plan:
- Load, default params, `in_valid` held 1 after reset release -> 12 handshakes; `wr_addr_x` 0..7 with `wr_en_x`, then `wr_addr_f` 0..3 with `wr_en_f`; `in_compute` high for the 4 cycles right after the 12th handshake.
- Full run, `out_ready` = 1 -> 5 `out_valid` pulses with `compute_cyc` 0..4; 4 `incr_comp_cyc` pulses; `done` once, 1 cycle after the 5th handshake; back in LOAD with `in_ready` = 1.
- Accumulator timing, RD_LAT=1 -> `acc_clr` & `acc_en` 1 cycle after the first `in_compute`; `acc_en` 4 cycles wide; `out_valid` rises 2 cycles after the last `in_compute`. Repeat with RD_LAT=3 -> rise after 4 cycles.
- Backpressure: `out_ready` = 0 for 3 cycles during output 2 -> `out_valid` held 4 cycles; `compute_cyc` stays 2; no `incr_comp_cyc` until the handshake.
- Input gaps: `in_valid` toggled 1,0,0,1,... and asserted during COMPUTE -> writes only on handshakes; addresses contiguous; no writes and no `load_cnt` change outside LOAD.
- Reset mid-run: `reset_n` low for 1 cycle mid-COMPUTE of output 3 -> immediate LOAD with `compute_cyc` = 0, `acc_en` = 0, `mem_wr_state` = 1; next load restarts at `wr_addr_x` = 0.

Source files
------------

// File: rtl/conv_sequencer_if.sv
// rtl/conv_sequencer_if.sv - stream-side handshake bundle for the convolution sequencer
interface conv_sequencer_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic done;

  modport master (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  done
  );

  modport slave (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid,
    output done
  );
endinterface

// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - control FSM for the 1-D convolution engine
// Sequences sample/tap load, per-output MAC bursts and result handoff; no datapath.
module conv_sequencer #(
  parameter int DATA_N      = 8,
  parameter int LG_DATA_N   = 3,
  parameter int FILTER_N    = 4,
  parameter int LG_FILTER_N = 2,
  parameter int LG_CONV_N   = 3,
  parameter int RD_LAT      = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  conv_sequencer_if.slave        bus,
  output logic                   wr_en_x,
  output logic [LG_DATA_N-1:0]   wr_addr_x,
  output logic                   wr_en_f,
  output logic [LG_FILTER_N-1:0] wr_addr_f,
  output logic                   mem_wr_state,
  output logic                   in_compute,
  output logic                   incr_comp_cyc,
  output logic [LG_CONV_N-1:0]   compute_cyc,
  output logic                   acc_clr,
  output logic                   acc_en
);
  localparam int CONV_N = DATA_N - FILTER_N + 1;
  localparam int LOAD_N = DATA_N + FILTER_N;
  localparam int LW     = $clog2(LOAD_N);
  localparam int DW     = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_COMPUTE,
    S_DRAIN,
    S_OUT,
    S_REINIT
  } state_t;

  state_t                 state_q, state_d;
  logic [LW-1:0]          load_cnt_q, load_cnt_d;
  logic [LG_FILTER_N-1:0] mac_cnt_q, mac_cnt_d;
  logic [DW-1:0]          drain_cnt_q, drain_cnt_d;
  logic                   reinit_cnt_q, reinit_cnt_d;
  logic [LG_CONV_N-1:0]   compute_cyc_q, compute_cyc_d;
  logic [RD_LAT-1:0]      acc_clr_line_q, acc_clr_line_d;
  logic [RD_LAT-1:0]      acc_en_line_q, acc_en_line_d;
  logic                   mem_wr_state_q, mem_wr_state_d;
  logic                   in_ready_q, in_ready_d;
  logic                   in_compute_q, in_compute_d;
  logic                   out_valid_q, out_valid_d;
  logic                   done_q, done_d;
  logic                   in_hs;
  logic                   out_hs;

  always_comb begin
    state_d        = state_q;
    load_cnt_d     = load_cnt_q;
    mac_cnt_d      = mac_cnt_q;
    drain_cnt_d    = drain_cnt_q;
    reinit_cnt_d   = reinit_cnt_q;
    compute_cyc_d  = compute_cyc_q;
    acc_clr_line_d = acc_clr_line_q;
    acc_en_line_d  = acc_en_line_q;
    done_d         = 1'b0;
    wr_en_x        = 1'b0;
    wr_en_f        = 1'b0;
    incr_comp_cyc  = 1'b0;
    in_hs          = bus.in_valid & in_ready_q;
    out_hs         = out_valid_q & bus.out_ready;

    case (state_q)
      S_LOAD: begin
        if (in_hs) begin
          // First DATA_N samples fill X memory, the remaining ones are taps.
          if (load_cnt_q < LW'(DATA_N)) begin
            wr_en_x = 1'b1;
          end else begin
            wr_en_f = 1'b1;
          end
          if (load_cnt_q == LW'(LOAD_N - 1)) begin
            state_d       = S_COMPUTE;
            load_cnt_d    = '0;
            mac_cnt_d     = '0;
            compute_cyc_d = '0;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        if (mac_cnt_q == LG_FILTER_N'(FILTER_N - 1)) begin
          state_d     = S_DRAIN;
          mac_cnt_d   = '0;
          drain_cnt_d = '0;
        end else begin
          mac_cnt_d = mac_cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // Wait for the last read to land in the accumulator before offering the result.
        if (drain_cnt_q == DW'(RD_LAT - 1)) begin
          state_d = S_OUT;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      S_OUT: begin
        if (out_hs) begin
          if (compute_cyc_q == LG_CONV_N'(CONV_N - 1)) begin
            state_d       = S_LOAD;
            compute_cyc_d = '0;
            done_d        = 1'b1;
          end else begin
            incr_comp_cyc = 1'b1;
            compute_cyc_d = compute_cyc_q + 1'b1;
            reinit_cnt_d  = 1'b0;
            state_d       = S_REINIT;
          end
        end
      end
      S_REINIT: begin
        if (reinit_cnt_q) begin
          state_d   = S_COMPUTE;
          mac_cnt_d = '0;
        end else begin
          reinit_cnt_d = 1'b1;
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase

    // Read-latency alignment: accumulator strobes trail the read cycles by RD_LAT.
    acc_en_line_d[0]  = in_compute_q;
    acc_clr_line_d[0] = in_compute_q & (mac_cnt_q == '0);
    for (int i = 1; i < RD_LAT; i++) begin
      acc_en_line_d[i]  = acc_en_line_q[i-1];
      acc_clr_line_d[i] = acc_clr_line_q[i-1];
    end

    mem_wr_state_d = (state_d == S_LOAD);
    in_ready_d     = (state_d == S_LOAD);
    in_compute_d   = (state_d == S_COMPUTE);
    out_valid_d    = (state_d == S_OUT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_LOAD;
      load_cnt_q     <= '0;
      mac_cnt_q      <= '0;
      drain_cnt_q    <= '0;
      reinit_cnt_q   <= 1'b0;
      compute_cyc_q  <= '0;
      acc_clr_line_q <= '0;
      acc_en_line_q  <= '0;
      mem_wr_state_q <= 1'b1;
      in_ready_q     <= 1'b1;
      in_compute_q   <= 1'b0;
      out_valid_q    <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      load_cnt_q     <= load_cnt_d;
      mac_cnt_q      <= mac_cnt_d;
      drain_cnt_q    <= drain_cnt_d;
      reinit_cnt_q   <= reinit_cnt_d;
      compute_cyc_q  <= compute_cyc_d;
      acc_clr_line_q <= acc_clr_line_d;
      acc_en_line_q  <= acc_en_line_d;
      mem_wr_state_q <= mem_wr_state_d;
      in_ready_q     <= in_ready_d;
      in_compute_q   <= in_compute_d;
      out_valid_q    <= out_valid_d;
      done_q         <= done_d;
    end
  end

  assign wr_addr_x     = wr_en_x ? LG_DATA_N'(load_cnt_q) : '0;
  assign wr_addr_f     = wr_en_f ? LG_FILTER_N'(load_cnt_q - LW'(DATA_N)) : '0;
  assign mem_wr_state  = mem_wr_state_q;
  assign in_compute    = in_compute_q;
  assign compute_cyc   = compute_cyc_q;
  assign acc_clr       = acc_clr_line_q[RD_LAT-1];
  assign acc_en        = acc_en_line_q[RD_LAT-1];
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_conv_sequencer.sv
// tb/tb_conv_sequencer.sv - scoreboard bench for conv_sequencer (RD_LAT=1 and RD_LAT=3 instances)
module tb_conv_sequencer;
  localparam int DATA_N   = 8;
  localparam int FILTER_N = 4;
  localparam int CONV_N   = 5;

  typedef struct {bit is_f; int addr;} wr_t;
  typedef struct {int cc; int len;} out_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_sequencer_if b1 ();
  conv_sequencer_if b3 ();

  logic       wr_en_x1, wr_en_f1, mem_wr_state1, in_compute1, incr1, acc_clr1, acc_en1;
  logic [2:0] wr_addr_x1, compute_cyc1;
  logic [1:0] wr_addr_f1;
  logic       wr_en_x3, wr_en_f3, mem_wr_state3, in_compute3, incr3, acc_clr3, acc_en3;
  logic [2:0] wr_addr_x3, compute_cyc3;
  logic [1:0] wr_addr_f3;

  conv_sequencer #(.RD_LAT(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(b1.slave),
    .wr_en_x(wr_en_x1), .wr_addr_x(wr_addr_x1), .wr_en_f(wr_en_f1), .wr_addr_f(wr_addr_f1),
    .mem_wr_state(mem_wr_state1), .in_compute(in_compute1), .incr_comp_cyc(incr1),
    .compute_cyc(compute_cyc1), .acc_clr(acc_clr1), .acc_en(acc_en1)
  );

  conv_sequencer #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .bus(b3.slave),
    .wr_en_x(wr_en_x3), .wr_addr_x(wr_addr_x3), .wr_en_f(wr_en_f3), .wr_addr_f(wr_addr_f3),
    .mem_wr_state(mem_wr_state3), .in_compute(in_compute3), .incr_comp_cyc(incr3),
    .compute_cyc(compute_cyc3), .acc_clr(acc_clr3), .acc_en(acc_en3)
  );

  wr_t  exp_wr[$];
  out_t exp_out[$];
  bit   exp_done = 0;
  int   n3_out = 0;
  int   n3_done = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_load();
    for (int i = 0; i < DATA_N; i++) exp_wr.push_back('{1'b0, i});
    for (int i = 0; i < FILTER_N; i++) exp_wr.push_back('{1'b1, i});
  endtask

  task automatic push_outs(input int stall_cc);
    for (int i = 0; i < CONV_N; i++) exp_out.push_back('{i, (i == stall_cc) ? 4 : 1});
  endtask

  task automatic do_load(input bit gaps);
    int hs = 0;
    int k = 0;
    while (hs < DATA_N + FILTER_N && k < 200) begin
      b1.in_valid = gaps ? (k % 3 == 0) : 1'b1;
      @(negedge clk);
      if (b1.in_valid && b1.in_ready) hs++;
      @(posedge clk); #1;
      k++;
    end
    chk("load_handshakes", hs, DATA_N + FILTER_N);
    b1.in_valid = gaps;
  endtask

  task automatic wait_done();
    int t = 0;
    do begin @(negedge clk); t++; end while (!b1.done && t < 400);
    chk("done_seen", int'(b1.done), 1);
    chk("reload_in_ready", int'(b1.in_ready), 1);
    chk("reload_mem_wr_state", int'(mem_wr_state1), 1);
    chk("reload_compute_cyc", int'(compute_cyc1), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_cc(input int v);
    int t = 0;
    do begin @(negedge clk); t++; end while (int'(compute_cyc1) != v && t < 400);
    chk("wait_compute_cyc", int'(compute_cyc1), v);
  endtask

  task automatic backpressure();
    int t = 0;
    wait_cc(2);
    @(posedge clk); #1 b1.out_ready = 1'b0;
    do begin @(negedge clk); t++; end while (!b1.out_valid && t < 100);
    chk("bp_out_valid_seen", int'(b1.out_valid), 1);
    repeat (3) @(posedge clk);
    #1 b1.out_ready = 1'b1;
  endtask

  task automatic reset_mid();
    int t = 0;
    wait_cc(3);
    do begin @(negedge clk); t++; end while (!in_compute1 && t < 100);
    chk("rst_in_compute_seen", int'(in_compute1), 1);
    @(posedge clk); #1 reset_n = 1'b0;
    #1;
    chk("rst_compute_cyc", int'(compute_cyc1), 0);
    chk("rst_acc_en", int'(acc_en1), 0);
    chk("rst_mem_wr_state", int'(mem_wr_state1), 1);
    chk("rst_in_compute", int'(in_compute1), 0);
    chk("rst_wr_queue", exp_wr.size(), 0);
    exp_out.delete();
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  // Monitor / scoreboard for the RD_LAT=1 instance
  initial begin : mon1
    wr_t w;
    out_t o;
    bit p_ic = 0, p_ae = 0, p_ov = 0;
    int ic_start = 0, ic_last = 0, ae_start = 0, ov_start = 0;
    int last_load_hs = -100, last_out_hs = -100;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        p_ic = 0; p_ae = 0; p_ov = 0; exp_done = 0;
        last_load_hs = -100; last_out_hs = -100;
      end else begin
        if (exp_done || b1.done) chk("done_pulse", int'(b1.done), int'(exp_done));
        exp_done = 0;
        if (in_compute1 || incr1 || wr_en_x1 || wr_en_f1)
          chk("strobe_excl", int'(in_compute1) + int'(incr1) + int'(wr_en_x1) + int'(wr_en_f1), 1);
        if (wr_en_x1 || wr_en_f1) begin
          chk("wr_on_handshake", int'(b1.in_valid & b1.in_ready), 1);
          chk("wr_pending", int'(exp_wr.size() > 0), 1);
          if (exp_wr.size() > 0) begin
            w = exp_wr.pop_front();
            chk("wr_sel_f", int'(wr_en_f1), int'(w.is_f));
            chk("wr_addr", wr_en_f1 ? int'(wr_addr_f1) : int'(wr_addr_x1), w.addr);
            if (w.is_f && w.addr == FILTER_N - 1) last_load_hs = cyc;
          end
        end
        if (in_compute1 && !p_ic) begin
          ic_start = cyc;
          if (last_load_hs >= 0) begin
            chk("ic_after_load", cyc - last_load_hs, 1);
            last_load_hs = -100;
          end else if (last_out_hs >= 0) begin
            chk("ic_after_reinit", cyc - last_out_hs, 3);
            last_out_hs = -100;
          end
        end
        if (!in_compute1 && p_ic) begin
          chk("ic_width", cyc - ic_start, FILTER_N);
          ic_last = cyc - 1;
        end
        if (acc_en1 || acc_clr1) chk("acc_clr_first_only", int'(acc_clr1), int'(acc_en1 && !p_ae));
        if (acc_en1 && !p_ae) begin
          chk("acc_en_delay", cyc - ic_start, 1);
          ae_start = cyc;
        end
        if (!acc_en1 && p_ae) chk("acc_en_width", cyc - ae_start, FILTER_N);
        if (b1.out_valid && !p_ov) begin
          chk("out_valid_rise", cyc - ic_last, 2);
          ov_start = cyc;
        end
        if (b1.out_valid) begin
          chk("out_pending", int'(exp_out.size() > 0), 1);
          if (exp_out.size() > 0) begin
            o = exp_out[0];
            chk("compute_cyc", int'(compute_cyc1), o.cc);
            chk("incr_comp_cyc", int'(incr1), int'(b1.out_ready && o.cc != CONV_N - 1));
            if (b1.out_ready) begin
              void'(exp_out.pop_front());
              chk("out_valid_len", cyc - ov_start + 1, o.len);
              if (o.cc == CONV_N - 1) exp_done = 1;
              else last_out_hs = cyc;
            end
          end
        end else if (incr1) begin
          chk("incr_outside_out", int'(incr1), 0);
        end
        p_ic = in_compute1;
        p_ae = acc_en1;
        p_ov = b1.out_valid;
      end
    end
  end

  // Timing monitor for the RD_LAT=3 instance
  initial begin : mon3
    bit q_ic = 0, q_ae = 0, q_ov = 0;
    int s3 = 0, l3 = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        q_ic = 0; q_ae = 0; q_ov = 0;
      end else begin
        if (in_compute3 && !q_ic) s3 = cyc;
        if (!in_compute3 && q_ic) l3 = cyc - 1;
        if (acc_en3 && !q_ae) begin
          chk("rl3_acc_en_delay", cyc - s3, 3);
          chk("rl3_acc_clr", int'(acc_clr3), 1);
        end
        if (b3.out_valid && !q_ov) chk("rl3_out_valid_rise", cyc - l3, 4);
        if (b3.out_valid && b3.out_ready) begin
          chk("rl3_compute_cyc", int'(compute_cyc3), n3_out);
          n3_out++;
        end
        if (b3.done) n3_done++;
        q_ic = in_compute3;
        q_ae = acc_en3;
        q_ov = b3.out_valid;
      end
    end
  end

  initial begin : rl3_stim
    int hs3 = 0;
    int t3 = 0;
    b3.in_valid  = 1'b0;
    b3.out_ready = 1'b1;
    while (!reset_n) @(posedge clk);
    #1 b3.in_valid = 1'b1;
    while (hs3 < DATA_N + FILTER_N && t3 < 100) begin
      @(negedge clk);
      if (b3.in_ready) hs3++;
      @(posedge clk); #1;
      t3++;
    end
    b3.in_valid = 1'b0;
    chk("rl3_load", hs3, DATA_N + FILTER_N);
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

  initial begin : main
    b1.in_valid  = 1'b0;
    b1.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", int'(b1.in_ready), 1);
    chk("reset_mem_wr_state", int'(mem_wr_state1), 1);
    chk("reset_out_valid", int'(b1.out_valid), 0);
    chk("reset_done", int'(b1.done), 0);
    chk("reset_in_compute", int'(in_compute1), 0);
    chk("reset_acc_en", int'(acc_en1), 0);
    chk("reset_compute_cyc", int'(compute_cyc1), 0);
    @(posedge clk); #1 reset_n = 1'b1;

    push_load(); push_outs(-1);
    do_load(1'b0);
    wait_done();

    push_load(); push_outs(2);
    do_load(1'b0);
    backpressure();
    wait_done();

    push_load(); push_outs(-1);
    do_load(1'b1);
    repeat (20) @(posedge clk);
    #1 b1.in_valid = 1'b0;
    wait_done();

    push_load(); push_outs(-1);
    do_load(1'b0);
    reset_mid();

    push_load(); push_outs(-1);
    do_load(1'b0);
    wait_done();

    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("out_queue_drained", exp_out.size(), 0);
    chk("rl3_outputs", n3_out, CONV_N);
    chk("rl3_done_count", n3_done, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
